// File: rtl/lif_spike_rate_monitor.sv
// lif_spike_rate_monitor
// Counts rising edges on each LIF spike channel over a fixed window of
// enabled clock cycles. At the end of each window the counts are copied
// into snapshot registers. The monitor also reports the most active channel,
// a per-channel saturation flag and a selectable snapshot readout.
//
// Channel map: [0]=final output, [1]=neuron1, [2]=neuron2, [3]=neuron3.

module lif_spike_rate_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int WIN_W  = 16,
  parameter int WINDOW = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [NUM_CH-1:0] spike_in,
  input  logic [1:0]        rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic              win_done,
  output logic [1:0]        winner_id,
  output logic              winner_valid,
  output logic [NUM_CH-1:0] ovf,
  output logic [WIN_W-1:0]  win_pos
);

  // Saturation value of a per-channel counter.
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // win_pos value in the last cycle of a window.
  // WINDOW may be as large as 2^WIN_W, so WINDOW-1 always fits in WIN_W bits.
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  logic [NUM_CH-1:0] prev;
  logic [NUM_CH-1:0] spike_edge;
  logic [NUM_CH-1:0] lovf;
  logic [NUM_CH-1:0] sat_now;
  logic [CNT_W-1:0]  live      [NUM_CH];
  logic [CNT_W-1:0]  snap      [NUM_CH];
  logic [CNT_W-1:0]  snap_next [NUM_CH];
  logic              win_end;
  logic [1:0]        winner_next;
  logic              winner_valid_next;
  logic [CNT_W-1:0]  best_cnt;

  // A rising edge is a high sample that was low in the previous cycle.
  // A pulse that stays high for several cycles is therefore counted once.
  assign spike_edge = spike_in & ~prev;

  // The window can only end in an enabled cycle.
  assign win_end = enable && (win_pos == WIN_LAST);

  // The snapshot readout is a plain mux, so it follows rd_sel immediately.
  assign rd_data = snap[rd_sel];

  // Track the previous spike level on every cycle, even when counting is
  // disabled. A spike that is already high when enable rises is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
    end else begin
      prev <= spike_in;
    end
  end

  // Compute the value each channel would hold if the window closed this
  // cycle. This includes an edge that lands in the final cycle. An edge that
  // arrives while the counter is already saturated is lost.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sat_now[i]   = 1'b0;
      snap_next[i] = live[i];
      if (spike_edge[i]) begin
        if (live[i] == CNT_MAX) begin
          sat_now[i] = 1'b1;
        end else begin
          snap_next[i] = live[i] + CNT_W'(1);
        end
      end
    end
  end

  // Find the winner among the new snapshot values. The comparison is strict,
  // so on a tie the lowest channel index wins.
  always_comb begin
    winner_next = 2'd0;
    best_cnt    = snap_next[0];
    for (int i = 1; i < NUM_CH; i++) begin
      if (snap_next[i] > best_cnt) begin
        best_cnt    = snap_next[i];
        winner_next = 2'(i);
      end
    end
    winner_valid_next = (best_cnt != '0);
  end

  // Update the live counters, live overflow flags and window position.
  // clear takes priority over both normal counting and the window end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_pos <= '0;
      lovf    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        live[i] <= '0;
      end
    end else if (clear) begin
      win_pos <= '0;
      lovf    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        live[i] <= '0;
      end
    end else if (enable) begin
      if (win_end) begin
        win_pos <= '0;
        lovf    <= '0;
        for (int i = 0; i < NUM_CH; i++) begin
          live[i] <= '0;
        end
      end else begin
        win_pos <= win_pos + WIN_W'(1);
        for (int i = 0; i < NUM_CH; i++) begin
          if (spike_edge[i]) begin
            if (live[i] == CNT_MAX) begin
              lovf[i] <= 1'b1;
            end else begin
              live[i] <= live[i] + CNT_W'(1);
            end
          end
        end
      end
    end
  end

  // At the end of a window, capture the snapshots, overflow flags and winner
  // together, and emit a one-cycle done pulse. A clear in the same cycle
  // suppresses the capture and forces the pulse low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_done     <= 1'b0;
      winner_id    <= 2'd0;
      winner_valid <= 1'b0;
      ovf          <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        snap[i] <= '0;
      end
    end else begin
      win_done <= 1'b0;
      if (!clear && win_end) begin
        win_done     <= 1'b1;
        winner_id    <= winner_next;
        winner_valid <= winner_valid_next;
        ovf          <= lovf | sat_now;
        for (int i = 0; i < NUM_CH; i++) begin
          snap[i] <= snap_next[i];
        end
      end
    end
  end

endmodule

// File: doc/lif_spike_rate_monitor.md
Name: lif_spike_rate_monitor

Overview:
Downstream consumer of the LIF neuron network's spike outputs (spike_1, spike_2, spike_3, spike_output). It counts rising edges per channel over a fixed window of clock cycles and, at window end, latches the counts into snapshot registers. It computes the winning (most active) channel and provides a selectable count readout. The readout data can be muxed onto spare uo_out bits at the top level.

Parameters:
NUM_CH, 4, number of spike channels (fixed at 4; the winner index is 2 bits)
CNT_W, 8, per-channel spike counter width; counters saturate at 2^CNT_W-1
WIN_W, 16, window counter width
WINDOW, 1000, window length in enabled clock cycles; legal range 2..2^WIN_W

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  high: window counter advances and edges are counted; low: both hold
clear  input  1  synchronous; zeroes live counters and window counter
spike_in  input  4  [0]=final, [1]=neuron1, [2]=neuron2, [3]=neuron3; synchronous to clk
rd_sel  input  2  selects the snapshot channel for rd_data
rd_data  output  CNT_W  snapshot count of the channel selected by rd_sel (combinational mux)
win_done  output  1  one-cycle pulse; snapshot, winner and overflow updated in this same cycle
winner_id  output  2  index of the highest snapshot count
winner_valid  output  1  high when the highest snapshot count is greater than 0
ovf  output  4  per-channel sticky saturation flag for the last completed window
win_pos  output  WIN_W  current window counter value (debug)

Behaviour:
- Reset (rst_n low, asynchronous):
  - live counters, snapshots, win_pos and the edge-detect prev register go to 0.
  - win_done, winner_id, winner_valid and ovf go to 0.
  - rd_data is therefore 0.
- Edge detect:
  - edge[i] = spike_in[i] & ~prev[i].
  - prev <= spike_in every cycle, regardless of enable.
  - A spike held high across enable rising is not counted.
  - A multi-cycle high pulse counts once.
- Live count:
  - When enable=1 and edge[i]=1, live[i] increments.
  - At 2^CNT_W-1, live[i] holds and sets a live overflow bit lovf[i].
- Window:
  - When enable=1, win_pos increments each cycle.
  - On the cycle with win_pos==WINDOW-1 and enable=1 (the window-end cycle), registered at the next edge:
    - snap[i] <= saturating(live[i] + edge[i]); an edge in the final cycle is included.
    - ovf[i] <= lovf[i] OR (saturation occurs in this cycle).
    - live <= 0, lovf <= 0, win_pos <= 0.
    - win_done <= 1 for exactly one cycle.
    - winner_id/winner_valid are computed from the new snap values and registered with them.
  - win_done is 0 in every other cycle.
- Winner rule:
  - Highest count wins; ties resolve to the lowest index.
  - All counts zero: winner_valid=0 and winner_id=0.
- enable low: win_pos, live and lovf hold; a window end cannot occur.
- clear:
  - Next state: live=0, lovf=0, win_pos=0.
  - snap, ovf, winner_id, winner_valid and win_done are unchanged, except that win_done is forced to 0.
  - clear has priority over enable and over a window end in the same cycle (no snapshot, no pulse).
- Reset mid-window: everything returns to its reset values; counting restarts from win_pos=0 once rst_n is released.
- rd_data = snap[rd_sel]; it changes combinationally with rd_sel and with snapshot updates.

Test Plan:
1. Reset, WINDOW=10, enable=1, spike_in[1] pulsed one cycle at every 2nd cycle (5 edges) -> win_done high at the 10th cycle after enable; snap[1]=5, winner_id=1, winner_valid=1, others 0, ovf=0.
2. Channels 2 and 3 both get 3 edges in one window -> winner_id=2 (tie goes to lowest index); rd_sel=3 gives rd_data=3.
3. CNT_W=4, 20 edges on channel 0 in one window -> snap[0]=15, ovf[0]=1; next window with 2 edges -> snap[0]=2, ovf[0]=0.
4. Edge arrives exactly in the window-end cycle -> included in snap; live after rollover is 0. spike_in[1] held high for 4 cycles -> counted once.
5. enable dropped for 7 cycles mid-window -> win_pos holds; win_done delayed by exactly 7 cycles. clear asserted in the window-end cycle -> no win_done, snapshots unchanged, win_pos=0.
6. rst_n pulsed low asynchronously mid-window with live counts of 3 -> all outputs 0 immediately; after release, the first win_done occurs WINDOW enabled cycles later.
